// File: rtl/ad9280_adc_decimator.sv
// Decimates the AD9280 sample stream before it reaches the scope core.
// Modes: bypass, skip (keep first of N), average (2^k window), peak (max then min).
// Ports:
//   adc_clk, adc_rst_n     sample clock; asynchronous active-low reset
//   enable                 run control, registered together with adc_data
//   mode, ratio, avg_log2  decimation configuration (any change restarts the window)
//   adc_data               raw converter sample
//   out_data, out_valid    decimated sample and its one-cycle strobe
//   out_is_max             peak mode: 1 = window max, 0 = window min
//   window_busy            a window is partially accumulated or a min is pending
module ad9280_adc_decimator #(
   parameter int DATA_WIDTH  = 8,
   parameter int RATIO_WIDTH = 16
) (
   input  logic                   adc_clk,
   input  logic                   adc_rst_n,
   input  logic                   enable,
   input  logic [1:0]             mode,
   input  logic [RATIO_WIDTH-1:0] ratio,
   input  logic [3:0]             avg_log2,
   input  logic [DATA_WIDTH-1:0]  adc_data,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic                   out_valid,
   output logic                   out_is_max,
   output logic                   window_busy
);

   // Counter must reach 255 for a 256-sample average even with a narrow ratio field.
   localparam int CW = (RATIO_WIDTH > 9) ? RATIO_WIDTH : 9;
   localparam int AW = DATA_WIDTH + 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_PEND = 2'd2;

   localparam logic [1:0] M_BYP  = 2'b00;
   localparam logic [1:0] M_SKIP = 2'b01;
   localparam logic [1:0] M_AVG  = 2'b10;
   localparam logic [1:0] M_PEAK = 2'b11;

   logic [DATA_WIDTH-1:0]  s0_data;
   logic                   s0_en;
   logic [1:0]             mode_q;
   logic [RATIO_WIDTH-1:0] ratio_q;
   logic [3:0]             avg_log2_q;

   logic [1:0]             state;
   logic [CW-1:0]          cnt;
   logic [AW-1:0]          acc;
   logic [DATA_WIDTH-1:0]  min_v, max_v, pend_min;

   logic [3:0]             shift;
   logic [CW-1:0]          win_len;
   logic                   single, first, last, cfg_chg;
   logic [AW-1:0]          acc_sum;
   logic [DATA_WIDTH-1:0]  nxt_min, nxt_max;

   always_comb begin
      shift   = (avg_log2 > 4'd8) ? 4'd8 : avg_log2;
      win_len = (mode == M_AVG) ? (CW'(1) << shift) : CW'(ratio);
      // Windows of length one degenerate to pass-through.
      single  = (mode == M_BYP) ||
                (mode == M_AVG && shift == 4'd0) ||
                (mode != M_AVG && ratio <= RATIO_WIDTH'(1));
      first   = (cnt == '0);
      last    = (cnt == win_len - CW'(1));
      acc_sum = (first ? '0 : acc) + AW'(s0_data);
      // First sample of a window seeds min/max.
      nxt_min = (first || s0_data < min_v) ? s0_data : min_v;
      nxt_max = (first || s0_data > max_v) ? s0_data : max_v;
      cfg_chg = (mode != mode_q) || (ratio != ratio_q) || (avg_log2 != avg_log2_q);
   end

   assign window_busy = (cnt != '0) || (state == ST_PEND);

   // Stage 0: sample and run control captured together; config snapshot for change detection.
   always_ff @(posedge adc_clk or negedge adc_rst_n) begin
      if (!adc_rst_n) begin
         s0_data    <= '0;
         s0_en      <= 1'b0;
         mode_q     <= '0;
         ratio_q    <= '0;
         avg_log2_q <= '0;
      end else begin
         s0_data    <= adc_data;
         s0_en      <= enable;
         mode_q     <= mode;
         ratio_q    <= ratio;
         avg_log2_q <= avg_log2;
      end
   end

   always_ff @(posedge adc_clk or negedge adc_rst_n) begin
      if (!adc_rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         acc        <= '0;
         min_v      <= '0;
         max_v      <= '0;
         pend_min   <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_is_max <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         out_is_max <= 1'b0;
         if (!s0_en || (state != ST_IDLE && cfg_chg)) begin
            // Idle, or config changed mid-window: drop partial window and any pending min.
            state <= ST_IDLE;
            cnt   <= '0;
            acc   <= '0;
            min_v <= '0;
            max_v <= '0;
         end else begin
            state <= ST_RUN;
            if (state == ST_PEND) begin
               out_data  <= pend_min;
               out_valid <= 1'b1;
            end
            if (single) begin
               out_data  <= s0_data;
               out_valid <= 1'b1;
               cnt       <= '0;
            end else begin
               // The sample arriving alongside a pending min opens the next window here.
               acc   <= acc_sum;
               min_v <= nxt_min;
               max_v <= nxt_max;
               cnt   <= last ? '0 : cnt + CW'(1);
               if (mode == M_SKIP && first) begin
                  out_data  <= s0_data;
                  out_valid <= 1'b1;
               end
               if (last && mode == M_AVG) begin
                  out_data  <= DATA_WIDTH'(acc_sum >> shift);
                  out_valid <= 1'b1;
               end
               if (last && mode == M_PEAK) begin
                  out_data   <= nxt_max;
                  out_valid  <= 1'b1;
                  out_is_max <= 1'b1;
                  pend_min   <= nxt_min;
                  state      <= ST_PEND;
               end
            end
         end
      end
   end

endmodule

// File: doc/ad9280_adc_decimator.md
AD9280_ADC_DECIMATOR -- requirements
Module: ad9280_adc_decimator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning ADC sample width.
REQ-002 SHALL have parameter RATIO_WIDTH, default 16, meaning decimation-ratio field width.
REQ-003 SHALL have port adc_clk  input  1  sample clock; all logic on its rising edge.
REQ-004 SHALL have port adc_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  run control; low holds block idle.
REQ-006 SHALL have port mode  input  2  00 bypass, 01 skip, 10 average, 11 peak.
REQ-007 SHALL have port ratio  input  RATIO_WIDTH  window length N for skip/peak modes.
REQ-008 SHALL have port avg_log2  input  4  window length N=2^avg_log2 for average mode; values above 8 are treated as 8.
REQ-009 SHALL have port adc_data  input  DATA_WIDTH  raw AD9280 sample.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  decimated sample, feeding the scope core's adc_data input.
REQ-011 SHALL have port out_valid  output  1  one-cycle strobe marking out_data valid.
REQ-012 SHALL have port out_is_max  output  1  peak mode only: 1 = window max, 0 = window min; 0 in other modes.
REQ-013 SHALL have port window_busy  output  1  high while a window is partially accumulated.

Function
REQ-014 SHALL register adc_data and enable together on every edge (stage 0); only samples whose captured enable=1 take part.
REQ-015 SHALL update out_data and out_valid one edge after stage 0; bypass latency is 2 edges from adc_data to out_data.
REQ-016 SHALL, in bypass mode, or in skip/peak mode with ratio 0 or 1, emit every participating sample with out_valid=1.
REQ-017 SHALL keep a window counter cnt running 0..N-1 on participating samples, wrapping from N-1 to 0.
REQ-018 SHALL, in skip mode, emit the sample taken at cnt=0 and drop the rest.
REQ-019 SHALL, in average mode, accumulate N samples in a DATA_WIDTH+8 bit accumulator and, at cnt=N-1, emit accumulator>>avg_log2, truncated with no rounding; avg_log2=0 behaves as bypass.
REQ-020 SHALL, in peak mode, track the running min and max; at cnt=N-1 it emits the max with out_is_max=1, and on the next edge the min with out_is_max=0.
REQ-021 SHALL hold the peak-mode pending min in a PEND state; a new window's first sample arriving during PEND SHALL still be accumulated and not lost.
REQ-022 SHALL implement the states IDLE, RUN and PEND:
  - IDLE->RUN on the first participating sample;
  - RUN->PEND on a peak-mode window end;
  - PEND->RUN after one edge;
  - any state->IDLE when captured enable=0.
REQ-023 SHALL, in IDLE, clear cnt, the accumulator and min/max, and force out_valid=0.
REQ-024 SHALL detect any change of mode, ratio or avg_log2, compared against a registered copy; on a change it SHALL discard the partial window, with no output, and restart at cnt=0 on the next participating sample.
REQ-025 SHALL initialise min/max from the window's first sample, not from constants.
REQ-026 SHALL drive window_busy high when cnt!=0 or the state is PEND.
REQ-027 SHALL keep out_data at its last emitted value while out_valid=0.
REQ-028 SHALL have no backpressure input; the downstream block samples every out_valid strobe.

Reset
REQ-029 SHALL, on adc_rst_n=0 and asynchronously, set the state to IDLE, out_data=0, out_valid=0, out_is_max=0, window_busy=0, cnt=0, accumulator=0, min/max=0, and the stage-0 registers to 0.
REQ-030 SHALL resume operation on the first adc_clk edge after reset release, with the window starting at cnt=0; a mid-window reset SHALL discard the partial window with no output.

Verification
REQ-031 Bypass: enable=1, mode=00, ramp 0..255 -> out_data follows the ramp 2 edges late, out_valid high continuously.
REQ-032 Skip: mode=01, ratio=4, ramp 0,1,2,... -> outputs 0,4,8,... with one out_valid per 4 samples.
REQ-033 Average: mode=10, avg_log2=2, inputs 10,11,12,14 -> a single output of 11 (47>>2), out_valid one edge after the 4th sample is registered.
REQ-034 Peak: mode=11, ratio=4, inputs 50,200,3,90 -> 200 with out_is_max=1, then 3 with out_is_max=0 on the next edge; a following window with continuous input is unaffected.
REQ-035 Config change: mode=10, avg_log2=3, change ratio... switch avg_log2 to 2 after 5 samples -> no output for the partial window; the next 4 samples produce one correct average.
REQ-036 Reset/enable: assert adc_rst_n=0 mid-window, or drop enable for 1 cycle -> all outputs 0, no spurious out_valid, and the next window is complete and correct.
